// File: rtl/ahb_apb_bridge.sv
// AHB-lite slave to APB bridge for NUM_APB_SLAVES peripherals, one transfer in flight, all outputs registered.
// Zero-wait latency: read 2 / write 3 hreadyout-low cycles; hreadyout stays low while the APB peripheral holds pready low.
module ahb_apb_bridge #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int NUM_APB_SLAVES = 4,
    parameter int SEL_LSB        = 12,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                                      i_clk,
    input  logic                                      i_reset,
    input  logic                                      i_hselx,
    input  logic                                      i_htrans,
    input  logic                                      i_hwrite,
    input  logic [ADDR_WIDTH-1:0]                     i_haddr,
    input  logic [DATA_WIDTH-1:0]                     i_hwdata,
    input  logic                                      i_hready,
    output logic                                      o_hreadyout,
    output logic [DATA_WIDTH-1:0]                     o_hrdata,
    output logic                                      o_hresp,
    output logic [ADDR_WIDTH-1:0]                     o_paddr,
    output logic [NUM_APB_SLAVES-1:0]                 o_psel,
    output logic                                      o_penable,
    output logic                                      o_pwrite,
    output logic [DATA_WIDTH-1:0]                     o_pwdata,
    input  logic [NUM_APB_SLAVES-1:0][DATA_WIDTH-1:0] i_prdata,
    input  logic [NUM_APB_SLAVES-1:0]                 i_pready,
    input  logic [NUM_APB_SLAVES-1:0]                 i_pslverr
);

    localparam int IDX_W = (NUM_APB_SLAVES > 1) ? $clog2(NUM_APB_SLAVES) : 1;
    localparam int RGN_W = ADDR_WIDTH - SEL_LSB;
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WDATA,
        S_SETUP,
        S_ACCESS,
        S_ERR1,
        S_ERR2
    } state_t;

    state_t                    state, state_nxt;
    logic [IDX_W-1:0]          idx, idx_nxt;
    logic [15:0]               tmo_cnt, tmo_cnt_nxt;
    logic                      hreadyout_nxt, hresp_nxt, penable_nxt, pwrite_nxt;
    logic [DATA_WIDTH-1:0]     hrdata_nxt, pwdata_nxt;
    logic [ADDR_WIDTH-1:0]     paddr_nxt;
    logic [NUM_APB_SLAVES-1:0] psel_nxt;

    logic                      accept, bad_addr, timeout_hit;
    logic [RGN_W-1:0]          region;
    logic [IDX_W-1:0]          haddr_idx;
    logic                      sel_ready, sel_err;
    logic [DATA_WIDTH-1:0]     sel_rdata;

    assign accept    = i_hselx & i_htrans & i_hready;
    assign region    = i_haddr[ADDR_WIDTH-1:SEL_LSB];
    assign haddr_idx = i_haddr[SEL_LSB +: IDX_W];
    // Every address bit above SEL_LSB takes part, so windows past the last peripheral decode as errors.
    assign bad_addr  = ({1'b0, region} >= (RGN_W + 1)'(NUM_APB_SLAVES));

    assign sel_ready   = i_pready[idx];
    assign sel_err     = i_pslverr[idx];
    assign sel_rdata   = i_prdata[idx];
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (tmo_cnt == TMO_LAST);

    always_comb begin
        state_nxt     = state;
        idx_nxt       = idx;
        tmo_cnt_nxt   = tmo_cnt;
        hreadyout_nxt = o_hreadyout;
        hresp_nxt     = o_hresp;
        hrdata_nxt    = o_hrdata;
        paddr_nxt     = o_paddr;
        psel_nxt      = o_psel;
        penable_nxt   = o_penable;
        pwrite_nxt    = o_pwrite;
        pwdata_nxt    = o_pwdata;

        case (state)
            S_IDLE, S_ERR2: begin
                state_nxt     = S_IDLE;
                hreadyout_nxt = 1'b1;
                hresp_nxt     = 1'b0;
                psel_nxt      = '0;
                penable_nxt   = 1'b0;
                if (accept) begin
                    idx_nxt       = haddr_idx;
                    paddr_nxt     = i_haddr;
                    pwrite_nxt    = i_hwrite;
                    hreadyout_nxt = 1'b0;
                    if (bad_addr) begin
                        state_nxt = S_ERR1;
                        hresp_nxt = 1'b1;
                    end else if (i_hwrite) begin
                        state_nxt = S_WDATA;
                    end else begin
                        state_nxt = S_SETUP;
                        psel_nxt  = NUM_APB_SLAVES'(1) << haddr_idx;
                    end
                end
            end
            S_WDATA: begin
                // hwdata belongs to the AHB data phase, one cycle after the address was accepted.
                state_nxt  = S_SETUP;
                pwdata_nxt = i_hwdata;
                psel_nxt   = NUM_APB_SLAVES'(1) << idx;
            end
            S_SETUP: begin
                state_nxt   = S_ACCESS;
                penable_nxt = 1'b1;
                tmo_cnt_nxt = '0;
            end
            S_ACCESS: begin
                if (sel_ready || timeout_hit) begin
                    psel_nxt    = '0;
                    penable_nxt = 1'b0;
                    if (sel_ready && !sel_err) begin
                        state_nxt     = S_IDLE;
                        hreadyout_nxt = 1'b1;
                        if (!o_pwrite) begin
                            hrdata_nxt = sel_rdata;
                        end
                    end else begin
                        state_nxt = S_ERR1;
                        hresp_nxt = 1'b1;
                    end
                end else begin
                    tmo_cnt_nxt = tmo_cnt + 16'd1;
                end
            end
            S_ERR1: begin
                state_nxt     = S_ERR2;
                hreadyout_nxt = 1'b1;
                hresp_nxt     = 1'b1;
            end
            default: begin
                state_nxt     = S_IDLE;
                hreadyout_nxt = 1'b1;
                hresp_nxt     = 1'b0;
                psel_nxt      = '0;
                penable_nxt   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state       <= S_IDLE;
            idx         <= '0;
            tmo_cnt     <= '0;
            o_hreadyout <= 1'b1;
            o_hresp     <= 1'b0;
            o_hrdata    <= '0;
            o_paddr     <= '0;
            o_psel      <= '0;
            o_penable   <= 1'b0;
            o_pwrite    <= 1'b0;
            o_pwdata    <= '0;
        end else begin
            state       <= state_nxt;
            idx         <= idx_nxt;
            tmo_cnt     <= tmo_cnt_nxt;
            o_hreadyout <= hreadyout_nxt;
            o_hresp     <= hresp_nxt;
            o_hrdata    <= hrdata_nxt;
            o_paddr     <= paddr_nxt;
            o_psel      <= psel_nxt;
            o_penable   <= penable_nxt;
            o_pwrite    <= pwrite_nxt;
            o_pwdata    <= pwdata_nxt;
        end
    end

endmodule

// File: tb/tb_ahb_apb_bridge.sv
// Scoreboard bench for ahb_apb_bridge: the driver pushes expected AHB and APB outcomes at address acceptance,
// independent monitors pop and compare when the DUT completes a transfer or opens an APB SETUP phase.
module tb_ahb_apb_bridge;

    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int NS    = 4;
    localparam int TMO   = 4;
    localparam int NRAND = 80;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 hselx = 1'b0, htrans = 1'b0, hwrite = 1'b0, hready = 1'b1;
    logic [AW-1:0]        haddr = '0;
    logic [DW-1:0]        hwdata = '0;
    logic                 hreadyout, hresp, penable, pwrite;
    logic [DW-1:0]        hrdata, pwdata;
    logic [AW-1:0]        paddr;
    logic [NS-1:0]        psel;
    logic [NS-1:0][DW-1:0] prdata = '0;
    logic [NS-1:0]        pready = '0, pslverr = '0;

    typedef struct {
        logic          err;
        logic [DW-1:0] hrdata;
        int            low;
    } ahb_exp_t;

    typedef struct {
        logic [AW-1:0] addr;
        int            idx;
        logic          wr;
        logic [DW-1:0] wdata;
        int            waits;
        logic          slverr;
        logic [DW-1:0] rdata;
        int            acc;
    } apb_exp_t;

    ahb_exp_t      ahb_q[$];
    apb_exp_t      apb_q[$];
    int            tests = 0;
    int            fails = 0;
    logic [DW-1:0] model_hrdata = '0;
    bit            apb_busy = 1'b0;

    ahb_apb_bridge #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_APB_SLAVES(NS), .SEL_LSB(12), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .i_clk(clk), .i_reset(rst), .i_hselx(hselx), .i_htrans(htrans), .i_hwrite(hwrite),
        .i_haddr(haddr), .i_hwdata(hwdata), .i_hready(hready), .o_hreadyout(hreadyout),
        .o_hrdata(hrdata), .o_hresp(hresp), .o_paddr(paddr), .o_psel(psel), .o_penable(penable),
        .o_pwrite(pwrite), .o_pwdata(pwdata), .i_prdata(prdata), .i_pready(pready), .i_pslverr(pslverr)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive_idle();
        hselx  = 1'b0;
        htrans = 1'b0;
        hwrite = 1'b0;
        hready = 1'b1;
        haddr  = $urandom;
        hwdata = $urandom;
    endtask

    // Bus activity that must never be accepted as a transfer.
    task automatic drive_noise();
        drive_idle();
        case ($urandom_range(0, 2))
            0:       begin hselx = 1'b1; htrans = 1'b0; end
            1:       begin hselx = 1'b0; htrans = 1'b1; end
            default: begin hselx = 1'b1; htrans = 1'b1; hready = 1'b0; end
        endcase
        hwrite = 1'($urandom);
    endtask

    task automatic wait_ready();
        int guard = 0;
        while (!hreadyout && guard < 100) begin
            @(negedge clk);
            drive_idle();
            guard++;
        end
        check("wait_hreadyout", 64'(hreadyout), 64'd1);
    endtask

    // Reference model: outcome of one accepted AHB transfer, from the address map and the peripheral's plan.
    task automatic issue(input logic [AW-1:0] addr, input logic wr, input logic [DW-1:0] wdata,
                         input int waits, input logic slverr, input logic [DW-1:0] rdata);
        ahb_exp_t a;
        apb_exp_t p;
        logic [AW-1:0] window;
        bit timed_out;
        window    = addr >> 12;
        timed_out = (waits >= TMO);
        hselx  = 1'b1;
        htrans = 1'b1;
        hready = 1'b1;
        haddr  = addr;
        hwrite = wr;
        if (window >= NS) begin
            a.err    = 1'b1;
            a.low    = 1;
            a.hrdata = model_hrdata;
        end else begin
            p.addr   = addr;
            p.idx    = int'(window);
            p.wr     = wr;
            p.wdata  = wdata;
            p.waits  = waits;
            p.slverr = slverr;
            p.rdata  = rdata;
            p.acc    = timed_out ? TMO : waits + 1;
            a.err    = timed_out || slverr;
            a.low    = (wr ? 1 : 0) + 1 + p.acc + (a.err ? 1 : 0);
            if (!a.err && !wr) model_hrdata = rdata;
            a.hrdata = model_hrdata;
            apb_q.push_back(p);
        end
        ahb_q.push_back(a);
    endtask

    task automatic run_txn(input logic [AW-1:0] addr, input logic wr, input logic [DW-1:0] wdata,
                           input int waits, input logic slverr, input logic [DW-1:0] rdata, input int gaps);
        wait_ready();
        repeat (gaps) begin
            drive_noise();
            @(negedge clk);
            drive_idle();
        end
        wait_ready();
        issue(addr, wr, wdata, waits, slverr, rdata);
        @(negedge clk);
        drive_idle();
        if (wr) hwdata = wdata;
    endtask

    task automatic drain();
        int guard = 0;
        while ((ahb_q.size() != 0 || apb_q.size() != 0 || apb_busy) && guard < 300) begin
            @(negedge clk);
            drive_idle();
            guard++;
        end
        check("drain_outstanding", 64'(ahb_q.size() + apb_q.size()), 64'd0);
    endtask

    // AHB monitor: one comparison set per completed transfer.
    initial begin
        int       low;
        logic     prev_resp;
        ahb_exp_t e;
        low       = 0;
        prev_resp = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                low       = 0;
                prev_resp = 1'b0;
            end else begin
                if (!hreadyout) begin
                    low++;
                end else if (low > 0) begin
                    if (ahb_q.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL ahb_unexpected: completion with nothing outstanding, hresp=%0b required none", hresp);
                    end else begin
                        e = ahb_q.pop_front();
                        check("ahb_wait_cycles", 64'(low), 64'(e.low));
                        check("ahb_hresp", 64'(hresp), 64'(e.err));
                        check("ahb_hresp_first_cycle", 64'(prev_resp), 64'(e.err));
                        check("ahb_hrdata", 64'(hrdata), 64'(e.hrdata));
                    end
                    low = 0;
                end
                prev_resp = hresp;
            end
        end
    end

    // APB peripherals and monitor: unselected peripherals drive random responses every cycle.
    initial begin
        apb_exp_t cur;
        int       acc;
        acc = 0;
        forever begin
            @(negedge clk);
            for (int s = 0; s < NS; s++) prdata[s] = $urandom;
            pready  = NS'($urandom);
            pslverr = NS'($urandom);
            if (rst) begin
                apb_busy = 1'b0;
            end else if (psel != '0 && !penable) begin
                if (apb_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL apb_unexpected: psel=0x%0h with no APB transfer expected", psel);
                    apb_busy = 1'b0;
                end else begin
                    cur      = apb_q.pop_front();
                    apb_busy = 1'b1;
                    acc      = 0;
                    check("setup_psel", 64'(psel), 64'(NS'(1) << cur.idx));
                    check("setup_paddr", 64'(paddr), 64'(cur.addr));
                    check("setup_pwrite", 64'(pwrite), 64'(cur.wr));
                    if (cur.wr) check("setup_pwdata", 64'(pwdata), 64'(cur.wdata));
                end
            end else if (psel != '0 && penable) begin
                if (apb_busy) begin
                    check("access_psel", 64'(psel), 64'(NS'(1) << cur.idx));
                    if (acc == cur.waits) begin
                        pready[cur.idx]  = 1'b1;
                        pslverr[cur.idx] = cur.slverr;
                        prdata[cur.idx]  = cur.rdata;
                    end else begin
                        pready[cur.idx] = 1'b0;
                    end
                    acc++;
                end
            end else if (apb_busy) begin
                check("access_cycles", 64'(acc), 64'(cur.acc));
                check("penable_after_access", 64'(penable), 64'd0);
                apb_busy = 1'b0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [AW-1:0] addr;
        int            guard;
        drive_idle();
        rst = 1'b1;
        #12;
        check("rst_hreadyout", 64'(hreadyout), 64'd1);
        check("rst_hresp", 64'(hresp), 64'd0);
        check("rst_hrdata", 64'(hrdata), 64'd0);
        check("rst_paddr", 64'(paddr), 64'd0);
        check("rst_psel", 64'(psel), 64'd0);
        check("rst_penable", 64'(penable), 64'd0);
        check("rst_pwrite", 64'(pwrite), 64'd0);
        check("rst_pwdata", 64'(pwdata), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        run_txn(32'h0000_1000, 1'b0, '0, 0, 1'b0, 32'hCAFE_0001, 0);
        run_txn(32'h0000_2010, 1'b1, 32'h1234_5678, 3, 1'b0, '0, 0);
        run_txn(32'h0000_0000, 1'b0, '0, 0, 1'b1, 32'hDEAD_BEEF, 1);
        run_txn(32'h0000_3008, 1'b0, '0, 6, 1'b0, 32'h5555_AAAA, 0);
        run_txn(32'h0000_5000, 1'b0, '0, 0, 1'b0, '0, 0);
        run_txn(32'h0000_1004, 1'b0, '0, 0, 1'b0, 32'h0BAD_F00D, 0);

        for (int n = 0; n < NRAND; n++) begin
            addr = (AW'($urandom_range(0, 5)) << 12) | (AW'($urandom_range(0, 1023)) << 2);
            run_txn(addr, 1'($urandom), $urandom,
                    ($urandom_range(0, 7) == 0) ? int'($urandom_range(4, 6)) : int'($urandom_range(0, 3)),
                    ($urandom_range(0, 7) == 0), $urandom,
                    ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 3)) : 0);
        end
        drain();

        // Asynchronous reset in the middle of an ACCESS phase.
        run_txn(32'h0000_3000, 1'b0, '0, 6, 1'b0, 32'h1111_2222, 0);
        guard = 0;
        while (!penable && guard < 20) begin
            @(posedge clk);
            #2;
            guard++;
        end
        check("reach_access", 64'(penable), 64'd1);
        #1;
        rst = 1'b1;
        #1;
        check("arst_psel", 64'(psel), 64'd0);
        check("arst_penable", 64'(penable), 64'd0);
        check("arst_hreadyout", 64'(hreadyout), 64'd1);
        check("arst_hresp", 64'(hresp), 64'd0);
        check("arst_hrdata", 64'(hrdata), 64'd0);
        ahb_q.delete();
        apb_q.delete();
        model_hrdata = '0;
        @(posedge clk);
        #2;
        rst = 1'b0;
        @(negedge clk);
        run_txn(32'h0000_2004, 1'b0, '0, 1, 1'b0, 32'h7777_0002, 0);
        run_txn(32'h0000_3ffc, 1'b1, 32'hA5A5_5A5A, 0, 1'b0, '0, 0);
        drain();
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
